// File: rtl/dda_step_if.sv
// Load and voxel-stream bundle for the DDA step engine.
interface dda_step_if #(
    parameter int W       = 32,
    parameter int COORD_W = 5
);
    logic               ld_valid;
    logic               ld_ready;
    logic [COORD_W-1:0] ld_ix, ld_iy, ld_iz;
    logic               ld_sx, ld_sy, ld_sz;
    logic [W-1:0]       ld_next_x, ld_next_y, ld_next_z;
    logic [W-1:0]       ld_inc_x, ld_inc_y, ld_inc_z;
    logic               abort;
    logic               vox_valid;
    logic               vox_ready;
    logic [COORD_W-1:0] vox_ix, vox_iy, vox_iz;
    logic [2:0]         vox_face_mask;
    logic [W-1:0]       vox_t;
    logic               vox_last;
    logic [1:0]         vox_exit;
    logic               busy;

    modport master (
        output ld_valid, ld_ix, ld_iy, ld_iz, ld_sx, ld_sy, ld_sz,
        output ld_next_x, ld_next_y, ld_next_z,
        output ld_inc_x, ld_inc_y, ld_inc_z, abort, vox_ready,
        input  ld_ready, vox_valid, vox_ix, vox_iy, vox_iz,
        input  vox_face_mask, vox_t, vox_last, vox_exit, busy
    );

    modport slave (
        input  ld_valid, ld_ix, ld_iy, ld_iz, ld_sx, ld_sy, ld_sz,
        input  ld_next_x, ld_next_y, ld_next_z,
        input  ld_inc_x, ld_inc_y, ld_inc_z, abort, vox_ready,
        output ld_ready, vox_valid, vox_ix, vox_iy, vox_iz,
        output vox_face_mask, vox_t, vox_last, vox_exit, busy
    );
endinterface

// File: rtl/dda_step_engine.sv
// Sequential voxel DDA walker: one ray in, one voxel beat per cycle out.
// DDA_MULTI_AXIS_EN: step all axes tied at the minimum timer together.
module dda_step_engine #(
    parameter int W         = 32,
    parameter int COORD_W   = 5,
    parameter int MAX_STEPS = 64
) (
    input logic         clk,
    input logic         rst,
    dda_step_if.slave   io
);
    localparam int CW = $clog2(MAX_STEPS + 1);
    localparam logic [COORD_W-1:0] IMAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] ix, iy, iz;
    logic               sx, sy, sz;
    logic [W-1:0]       tx, ty, tz;
    logic [W-1:0]       incx, incy, incz;
    logic [2:0]         face;
    logic [W-1:0]       tout;
    logic [CW-1:0]      cnt;

    logic [W-1:0] tmin;
    logic [2:0]   sel;
    logic         oog, lim, last, run, fire, load;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? '1 : s[W-1:0];
    endfunction

    always_comb begin
        tmin = tx;
        if (ty < tmin) tmin = ty;
        if (tz < tmin) tmin = tz;
`ifdef DDA_MULTI_AXIS_EN
        sel = {tz == tmin, ty == tmin, tx == tmin};
`else
        sel = 3'b000;
        if (tx == tmin)      sel = 3'b001;
        else if (ty == tmin) sel = 3'b010;
        else                 sel = 3'b100;
`endif
    end

    // An axis leaves the grid only if it is actually being stepped.
    assign oog = (sel[0] && (sx ? (ix == IMAX) : (ix == '0)))
              || (sel[1] && (sy ? (iy == IMAX) : (iy == '0)))
              || (sel[2] && (sz ? (iz == IMAX) : (iz == '0)));
    assign lim  = (cnt == CW'(MAX_STEPS - 1));
    assign last = oog || lim;

    assign run  = (state_q == RUN);
    assign fire = run && io.vox_ready && !io.abort;
    assign load = !run && io.ld_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (io.ld_valid) state_d = RUN;
            RUN: begin
                if (io.abort)          state_d = IDLE;
                else if (fire && last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ix   <= '0; iy   <= '0; iz   <= '0;
            sx   <= 1'b0; sy <= 1'b0; sz <= 1'b0;
            tx   <= '0; ty   <= '0; tz   <= '0;
            incx <= '0; incy <= '0; incz <= '0;
            face <= '0;
            tout <= '0;
            cnt  <= '0;
        end else if (load) begin
            ix   <= io.ld_ix;     iy   <= io.ld_iy;     iz   <= io.ld_iz;
            sx   <= io.ld_sx;     sy   <= io.ld_sy;     sz   <= io.ld_sz;
            tx   <= io.ld_next_x; ty   <= io.ld_next_y; tz   <= io.ld_next_z;
            incx <= io.ld_inc_x;  incy <= io.ld_inc_y;  incz <= io.ld_inc_z;
            face <= '0;
            tout <= '0;
            cnt  <= '0;
        end else if (fire && !last) begin
            if (sel[0]) begin
                ix <= sx ? ix + 1'b1 : ix - 1'b1;
                tx <= sat_add(tx, incx);
            end
            if (sel[1]) begin
                iy <= sy ? iy + 1'b1 : iy - 1'b1;
                ty <= sat_add(ty, incy);
            end
            if (sel[2]) begin
                iz <= sz ? iz + 1'b1 : iz - 1'b1;
                tz <= sat_add(tz, incz);
            end
            face <= sel;
            tout <= tmin;
            cnt  <= cnt + 1'b1;
        end
    end

    assign io.ld_ready      = !run;
    assign io.busy          = run;
    assign io.vox_valid     = run;
    assign io.vox_ix        = ix;
    assign io.vox_iy        = iy;
    assign io.vox_iz        = iz;
    assign io.vox_face_mask = face;
    assign io.vox_t         = tout;
    assign io.vox_last      = run && last;
    assign io.vox_exit      = !run ? 2'd0 : oog ? 2'd1 : lim ? 2'd2 : 2'd0;
endmodule
